// File: rtl/dma_sched_pkg.sv
// rtl/dma_sched_pkg.sv - shared types and defaults for the DMA channel scheduler
package dma_sched_pkg;

  localparam int          NUM_CH_DEF   = 2;
  localparam logic [15:0] WDOG_MAX_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter
  import dma_sched_pkg::*;
#(
  parameter int N  = NUM_CH_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Walk channels last+1 .. last+N (mod N); the first requester found wins
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last) + i) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/dma_scheduler.sv
// rtl/dma_scheduler.sv - per-channel request slots feeding one DMA engine round-robin
module dma_scheduler
  import dma_sched_pkg::*;
#(
  parameter int          NUM_CH   = NUM_CH_DEF,
  parameter int          ADDR_W   = 32,
  parameter int          QTY_W    = 32,
  parameter logic [15:0] WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_valid_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  input  logic [NUM_CH*ADDR_W-1:0] req_src_i,
  input  logic [NUM_CH*ADDR_W-1:0] req_dst_i,
  input  logic [NUM_CH*QTY_W-1:0]  req_qty_i,
  output logic [NUM_CH-1:0]        done_o,
  output logic [NUM_CH-1:0]        irq_o,
  input  logic [NUM_CH-1:0]        irq_clr_i,
  output logic                     dma_en_o,
  output logic [ADDR_W-1:0]        dma_src_o,
  output logic [ADDR_W-1:0]        dma_dst_o,
  output logic [QTY_W-1:0]         dma_qty_o,
  input  logic                     dma_fin_i,
  output logic                     busy_o,
  output logic                     wdog_err_o
);

  localparam int IW = $clog2(NUM_CH);

  state_t              state;
  logic [NUM_CH-1:0]   slot_valid;
  logic [ADDR_W-1:0]   slot_src [NUM_CH];
  logic [ADDR_W-1:0]   slot_dst [NUM_CH];
  logic [QTY_W-1:0]    slot_qty [NUM_CH];
  logic [IW-1:0]       grant_q;
  logic [IW-1:0]       last_grant;
  logic [NUM_CH-1:0]   grant_oh;
  logic [NUM_CH-1:0]   irq_set;
  logic [NUM_CH-1:0]   arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [15:0]         wdog_cnt;

  assign req_ready_o = ~slot_valid;
  assign busy_o      = (state != S_IDLE);
  assign grant_oh    = NUM_CH'(1) << grant_q;
  assign irq_set     = (state == S_DONE) ? grant_oh : '0;

  rr_arbiter #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_arb (
    .req  (slot_valid),
    .last (last_grant),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  // Slot load on handshake; the granted slot frees itself at the end of DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        slot_src[c] <= '0;
        slot_dst[c] <= '0;
        slot_qty[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (state == S_DONE && grant_oh[c]) begin
          slot_valid[c] <= 1'b0;
        end else if (req_valid_i[c] && !slot_valid[c]) begin
          slot_valid[c] <= 1'b1;
          slot_src[c]   <= req_src_i[c*ADDR_W +: ADDR_W];
          slot_dst[c]   <= req_dst_i[c*ADDR_W +: ADDR_W];
          slot_qty[c]   <= req_qty_i[c*QTY_W +: QTY_W];
        end
      end
    end
  end

  // Sticky interrupts; a set in the same cycle as a clear takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_o <= '0;
    end else begin
      irq_o <= (irq_o & ~irq_clr_i) | irq_set;
    end
  end

  // Scheduler FSM with registered engine handshake, completion and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      grant_q    <= '0;
      last_grant <= IW'(NUM_CH - 1);
      wdog_cnt   <= '0;
      wdog_err_o <= 1'b0;
      dma_en_o   <= 1'b0;
      dma_src_o  <= '0;
      dma_dst_o  <= '0;
      dma_qty_o  <= '0;
      done_o     <= '0;
    end else begin
      dma_en_o <= 1'b0;
      done_o   <= '0;
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            grant_q <= arb_idx;
            if (slot_qty[arb_idx] == '0) begin
              // Nothing to move: complete without touching the engine
              state  <= S_DONE;
              done_o <= arb_gnt;
            end else begin
              state     <= S_LAUNCH;
              dma_en_o  <= 1'b1;
              dma_src_o <= slot_src[arb_idx];
              dma_dst_o <= slot_dst[arb_idx];
              dma_qty_o <= slot_qty[arb_idx];
              wdog_cnt  <= '0;
            end
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (dma_fin_i) begin
            state     <= S_DONE;
            done_o    <= grant_oh;
            dma_src_o <= '0;
            dma_dst_o <= '0;
            dma_qty_o <= '0;
          end else if (wdog_cnt != WDOG_MAX) begin
            // Flag a stuck engine but keep waiting; the counter saturates
            wdog_cnt <= wdog_cnt + 16'd1;
            if (wdog_cnt + 16'd1 == WDOG_MAX) begin
              wdog_err_o <= 1'b1;
            end
          end
        end
        S_DONE: begin
          last_grant <= grant_q;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_scheduler.sv
// tb/tb_dma_scheduler.sv - directed self-checking bench for dma_scheduler
module tb_dma_scheduler;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int QTY_W  = 32;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH-1:0]        req_valid_i = '0;
  logic [NUM_CH-1:0]        req_ready_o;
  logic [NUM_CH*ADDR_W-1:0] req_src_i = '0;
  logic [NUM_CH*ADDR_W-1:0] req_dst_i = '0;
  logic [NUM_CH*QTY_W-1:0]  req_qty_i = '0;
  logic [NUM_CH-1:0]        done_o;
  logic [NUM_CH-1:0]        irq_o;
  logic [NUM_CH-1:0]        irq_clr_i = '0;
  logic                     dma_en_o;
  logic [ADDR_W-1:0]        dma_src_o;
  logic [ADDR_W-1:0]        dma_dst_o;
  logic [QTY_W-1:0]         dma_qty_o;
  logic                     dma_fin_i = 1'b0;
  logic                     busy_o;
  logic                     wdog_err_o;

  always #5 clk = ~clk;

  dma_scheduler #(
    .NUM_CH   (NUM_CH),
    .ADDR_W   (ADDR_W),
    .QTY_W    (QTY_W),
    .WDOG_MAX (16'd8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_src_i   (req_src_i),
    .req_dst_i   (req_dst_i),
    .req_qty_i   (req_qty_i),
    .done_o      (done_o),
    .irq_o       (irq_o),
    .irq_clr_i   (irq_clr_i),
    .dma_en_o    (dma_en_o),
    .dma_src_o   (dma_src_o),
    .dma_dst_o   (dma_dst_o),
    .dma_qty_o   (dma_qty_o),
    .dma_fin_i   (dma_fin_i),
    .busy_o      (busy_o),
    .wdog_err_o  (wdog_err_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine-start and completion monitor, sampled on the falling edge
  int          cyc      = 0;
  int          en_cnt   = 0;
  int          done_cnt = 0;
  int          prev_en  = -1;
  int          min_gap  = 1000;
  logic [31:0] en_src_q[$];

  always @(negedge clk) begin
    cyc++;
    if (dma_en_o) begin
      en_cnt++;
      if (prev_en >= 0 && (cyc - prev_en) < min_gap) min_gap = cyc - prev_en;
      prev_en = cyc;
      en_src_q.push_back(dma_src_o);
    end
    if (done_o != '0) done_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n       = 1'b0;
    req_valid_i = '0;
    irq_clr_i   = '0;
    dma_fin_i   = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic set_req(input int ch, input logic [31:0] src, input logic [31:0] dst,
                         input logic [31:0] qty);
    req_src_i[ch*ADDR_W +: ADDR_W] = src;
    req_dst_i[ch*ADDR_W +: ADDR_W] = dst;
    req_qty_i[ch*QTY_W +: QTY_W]   = qty;
    req_valid_i[ch]                = 1'b1;
  endtask

  task automatic wait_en;
    int n;
    n = 0;
    while (!dma_en_o && n < 30) begin
      tick;
      n++;
    end
    check("en_seen", dma_en_o, 1'b1);
  endtask

  task automatic finish_xfer(input int delay);
    repeat (delay) tick;
    dma_fin_i = 1'b1;
    tick;
    dma_fin_i = 1'b0;
  endtask

  int e0;
  int d0;

  initial begin
    // Reset values
    tick;
    tick;
    check("rst_ready", req_ready_o, 2'b11);
    check("rst_busy", busy_o, 1'b0);
    check("rst_en", dma_en_o, 1'b0);
    check("rst_done", done_o, 2'b00);
    check("rst_irq", irq_o, 2'b00);
    check("rst_wdog", wdog_err_o, 1'b0);
    check("rst_src", dma_src_o, 32'h0);
    rst_n = 1'b1;
    tick;

    // Single request, fin 20 cycles after the start pulse
    e0 = en_cnt;
    set_req(0, 32'h1000_0000, 32'h2000_0000, 32'h10);
    tick;
    req_valid_i = '0;
    check("t1_ready_low", req_ready_o, 2'b10);
    tick;
    check("t1_en", dma_en_o, 1'b1);
    check("t1_src", dma_src_o, 32'h1000_0000);
    check("t1_dst", dma_dst_o, 32'h2000_0000);
    check("t1_qty", dma_qty_o, 32'h10);
    repeat (19) tick;
    check("t1_src_hold", dma_src_o, 32'h1000_0000);
    check("t1_en_low", dma_en_o, 1'b0);
    tick;
    dma_fin_i = 1'b1;
    tick;
    dma_fin_i = 1'b0;
    check("t1_done", done_o, 2'b01);
    check("t1_wdog_long", wdog_err_o, 1'b1);
    tick;
    check("t1_irq", irq_o, 2'b01);
    check("t1_done_pulse", done_o, 2'b00);
    check("t1_ready_back", req_ready_o, 2'b11);
    check("t1_src_zero", dma_src_o, 32'h0);
    check("t1_idle", busy_o, 1'b0);
    check("t1_one_en", en_cnt - e0, 1);

    // Contention: three rounds of simultaneous requests
    do_reset;
    en_src_q.delete();
    prev_en = -1;
    min_gap = 1000;
    for (int r = 0; r < 3; r++) begin
      set_req(0, 32'hA000_0000 + r, 32'h0, 32'h4);
      set_req(1, 32'hB000_0000 + r, 32'h0, 32'h4);
      tick;
      req_valid_i = '0;
      check("t2_both_taken", req_ready_o, 2'b00);
      wait_en;
      finish_xfer(1);
      check("t2_done_ch0", done_o, 2'b01);
      wait_en;
      finish_xfer(1);
      check("t2_done_ch1", done_o, 2'b10);
      tick;
    end
    check("t2_en_count", en_src_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < en_src_q.size()) check("t2_order", en_src_q[i][31:28], (i % 2) ? 4'hB : 4'hA);
    end
    check("t2_min_gap", min_gap, 4);

    // Zero quantity completes without engine start
    e0 = en_cnt;
    set_req(1, 32'h0, 32'h0, 32'h0);
    tick;
    req_valid_i = '0;
    check("t3_no_done_yet", done_o, 2'b00);
    tick;
    check("t3_done", done_o, 2'b10);
    check("t3_busy", busy_o, 1'b1);
    tick;
    check("t3_irq1", irq_o[1], 1'b1);
    check("t3_no_en", en_cnt - e0, 0);

    // Interrupt clear racing the set
    irq_clr_i = 2'b11;
    tick;
    irq_clr_i = '0;
    check("t4_irq_cleared", irq_o, 2'b00);
    set_req(0, 32'hC000_0000, 32'hD000_0000, 32'h8);
    tick;
    req_valid_i = '0;
    wait_en;
    finish_xfer(2);
    check("t4_done", done_o, 2'b01);
    irq_clr_i = 2'b01;
    tick;
    check("t4_set_wins", irq_o[0], 1'b1);
    tick;
    check("t4_clear_later", irq_o[0], 1'b0);
    irq_clr_i = '0;

    // Watchdog with limit 8, late fin
    do_reset;
    check("t5_err_reset", wdog_err_o, 1'b0);
    e0 = en_cnt;
    set_req(0, 32'hE000_0000, 32'hF000_0000, 32'h4);
    tick;
    req_valid_i = '0;
    wait_en;
    repeat (8) tick;
    check("t5_err_before", wdog_err_o, 1'b0);
    tick;
    check("t5_err_set", wdog_err_o, 1'b1);
    repeat (20) tick;
    check("t5_still_busy", busy_o, 1'b1);
    check("t5_qty_hold", dma_qty_o, 32'h4);
    check("t5_err_sticky", wdog_err_o, 1'b1);
    dma_fin_i = 1'b1;
    tick;
    dma_fin_i = 1'b0;
    check("t5_late_done", done_o, 2'b01);
    check("t5_one_en", en_cnt - e0, 1);
    tick;

    // Reset while waiting on the engine
    d0 = done_cnt;
    set_req(0, 32'h1111_0000, 32'h2222_0000, 32'h4);
    set_req(1, 32'h3333_0000, 32'h4444_0000, 32'h4);
    tick;
    req_valid_i = '0;
    wait_en;
    tick;
    tick;
    check("t6_in_wait", busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_ready", req_ready_o, 2'b11);
    check("t6_busy", busy_o, 1'b0);
    check("t6_irq", irq_o, 2'b00);
    check("t6_wdog", wdog_err_o, 1'b0);
    check("t6_src", dma_src_o, 32'h0);
    check("t6_qty", dma_qty_o, 32'h0);
    tick;
    rst_n = 1'b1;
    repeat (6) tick;
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_idle_after", busy_o, 1'b0);
    check("t6_ready_after", req_ready_o, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_scheduler.md
DMA_SCHEDULER -- requirements
Module: dma_scheduler

Interface
REQ-001 Parameters SHALL be `NUM_CH` (default 2), the number of requester channels, range 2..4.
REQ-002 Parameter `ADDR_W` SHALL default to 32 and set the address width.
REQ-003 Parameter `QTY_W` SHALL default to 32 and set the transfer-quantity width.
REQ-004 Parameter `WDOG_MAX` SHALL default to 16'hFFFF and set the watchdog limit, in cycles, while waiting for the engine.
REQ-005 Ports SHALL be as listed, one per line.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  NUM_CH  per-channel request valid.
- `req_ready_o`  out  NUM_CH  per-channel slot free.
- `req_src_i`  in  NUM_CH*ADDR_W  source address, packed per channel.
- `req_dst_i`  in  NUM_CH*ADDR_W  destination address, packed per channel.
- `req_qty_i`  in  NUM_CH*QTY_W  word count, packed per channel.
- `done_o`  out  NUM_CH  one-cycle completion pulse per channel.
- `irq_o`  out  NUM_CH  sticky completion interrupt.
- `irq_clr_i`  in  NUM_CH  write-1-to-clear for `irq_o`.
- `dma_en_o`  out  1  start pulse to the DMA engine.
- `dma_src_o`  out  ADDR_W  engine source address.
- `dma_dst_o`  out  ADDR_W  engine destination address.
- `dma_qty_o`  out  QTY_W  engine word count.
- `dma_fin_i`  in  1  engine completion pulse.
- `busy_o`  out  1  high when the FSM is not in IDLE.
- `wdog_err_o`  out  1  sticky watchdog error.

Function
REQ-006 Each channel SHALL own one slot register holding {valid, src, dst, qty}; `req_ready_o[c]` SHALL equal ~slot_valid[c], taken from the register with no combinational path from inputs.
REQ-007 A request SHALL be accepted on a cycle with `req_valid_i[c]` && `req_ready_o[c]`; the slot SHALL load and become valid on the next edge.
REQ-008 The FSM states SHALL be IDLE, LAUNCH, WAIT and DONE.
REQ-009 IDLE transition: if any slot is valid, the FSM SHALL grant one channel by round-robin and go to LAUNCH, or to DONE if the granted qty==0. Otherwise it SHALL stay in IDLE.
REQ-010 Round-robin rule: search starts at (last_grant+1) mod NUM_CH; last_grant resets to NUM_CH-1, so channel 0 wins first after reset.
REQ-011 LAUNCH SHALL assert `dma_en_o` for exactly one cycle, with `dma_src_o`/`dma_dst_o`/`dma_qty_o` driven from the granted slot, then go to WAIT.
REQ-012 The `dma_*` address/qty outputs SHALL stay stable from LAUNCH until leaving WAIT, and SHALL be 0 otherwise.
REQ-013 WAIT SHALL go to DONE on `dma_fin_i`; a `dma_fin_i` in any other state SHALL be ignored.
REQ-014 The WAIT watchdog SHALL count cycles in WAIT; on reaching WDOG_MAX it SHALL set `wdog_err_o`, saturate, and keep waiting (no abort). The counter SHALL clear on entry to LAUNCH.
REQ-015 DONE SHALL last one cycle: pulse `done_o[g]`, set `irq_o[g]`, clear slot_valid[g], update last_grant=g, then go to IDLE.
REQ-016 Minimum spacing between consecutive `dma_en_o` pulses SHALL be 4 cycles: IDLE, LAUNCH, WAIT≥1, DONE.
REQ-017 Zero-qty requests SHALL complete via IDLE→DONE with no `dma_en_o`.
REQ-018 If `irq_clr_i[c]` and the set for channel c occur in the same cycle, set SHALL win.
REQ-019 A channel's slot clearing in DONE SHALL make `req_ready_o` high on the following cycle; there SHALL be no same-cycle refill.
REQ-020 Slots of non-granted channels SHALL accept requests in any state.
REQ-021 `busy_o` SHALL be (state != IDLE).

Reset
REQ-022 On `rst_n` low, asynchronously: state=IDLE, all slots invalid, last_grant=NUM_CH-1, watchdog=0; `dma_en_o`/`done_o`/`irq_o`/`wdog_err_o`/`busy_o`/`dma_*` = 0; `req_ready_o` = all ones.
REQ-023 Reset mid-transfer SHALL drop all slots with no `done_o`; the engine is reset by the same `rst_n`.
REQ-024 `wdog_err_o` SHALL clear only on reset.

Structure
REQ-025 Package `dma_sched_pkg` SHALL hold the FSM state enum, the default NUM_CH, and WDOG_MAX.
REQ-026 Round-robin selection SHALL be the sub-module `rr_arbiter` (inputs: request vector, last_grant; outputs: one-hot grant, grant index, any), purely combinational.

Verification
REQ-027 Single request: ch0 src=0x1000_0000, dst=0x2000_0000, qty=0x10, fin 20 cycles after `dma_en_o` -> one `dma_en_o` pulse with matching outputs; `done_o[0]` 1 cycle after fin; `irq_o[0]`=1.
REQ-028 Contention: ch0 and ch1 request in the same cycle, 3 back-to-back rounds -> grant order 0,1,0,1,0,1; each `dma_en_o` ≥4 cycles apart.
REQ-029 Zero qty: ch1 qty=0 -> `done_o[1]` 2 cycles after acceptance; no `dma_en_o`.
REQ-030 Interrupt race: `irq_clr_i[0]` asserted in the DONE cycle of ch0 -> `irq_o[0]` remains 1; a clear one cycle later -> 0.
REQ-031 Watchdog: WDOG_MAX=8, no fin -> `wdog_err_o`=1 after 8 WAIT cycles; a late fin still produces `done_o`.
REQ-032 Reset in WAIT: `rst_n` low for 1 cycle -> all outputs at reset values; `req_ready_o`=all ones; no `done_o`.
